// File: rtl/pipe_adder_if.sv
// Valid/ready bus for the pipelined adder: operand beat in, result beat out.
interface pipe_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, carry registered
// between stages, whole pipe stalls as a unit on output back-pressure.
module pipe_adder_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  input  logic             i_c,
  output logic [CHUNK-1:0] o_s,
  output logic             o_c
);
  assign {o_c, o_s} = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_c};
endmodule

module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  pipe_adder_if.slave  bus
);
  // WIDTH must be a multiple of STAGES
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] r_vld_pipe;
  logic              w_adv;
  logic              w_acc;
  logic [WIDTH-1:0]  w_bp;
  logic              w_c0;

  logic [WIDTH-1:0]  r_sum;
  logic              r_cout;
  logic              r_ovf;
  logic              r_zero;

  assign w_bp  = bus.sub ? ~bus.b : bus.b;
  assign w_c0  = bus.sub | bus.cin;
  assign w_adv = ~(r_vld_pipe[STAGES-1] & ~bus.out_ready);
  assign w_acc = bus.in_valid & w_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_vld_pipe <= '0;
    else if (w_adv) r_vld_pipe <= (r_vld_pipe << 1) | STAGES'(w_acc);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // IW: operand bits not yet consumed on entry; SW: sum bits known on exit
    localparam int IW = WIDTH - k * CHUNK;
    localparam int SW = (k + 1) * CHUNK;

    logic [IW-1:0]    w_a_src;
    logic [IW-1:0]    w_b_src;
    logic             w_ci;
    logic [CHUNK-1:0] w_s;
    logic             w_co;
    logic [SW-1:0]    w_sum_nx;

    pipe_adder_slice #(.CHUNK(CHUNK)) u_slice (
      .i_a (w_a_src[CHUNK-1:0]),
      .i_b (w_b_src[CHUNK-1:0]),
      .i_c (w_ci),
      .o_s (w_s),
      .o_c (w_co)
    );

    if (k == 0) begin : g_src
      assign w_a_src  = bus.a;
      assign w_b_src  = w_bp;
      assign w_ci     = w_c0;
      assign w_sum_nx = w_s;
    end else begin : g_src
      assign w_a_src  = g_st[k-1].g_reg.r_a;
      assign w_b_src  = g_st[k-1].g_reg.r_b;
      assign w_ci     = g_st[k-1].g_reg.r_c;
      assign w_sum_nx = {w_s, g_st[k-1].g_reg.r_sum};
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int RW = WIDTH - SW;
      logic [RW-1:0] r_a;
      logic [RW-1:0] r_b;
      logic [SW-1:0] r_sum;
      logic          r_c;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a   <= '0;
          r_b   <= '0;
          r_sum <= '0;
          r_c   <= 1'b0;
        end else if (w_adv) begin
          r_a   <= w_a_src[IW-1:CHUNK];
          r_b   <= w_b_src[IW-1:CHUNK];
          r_sum <= w_sum_nx;
          r_c   <= w_co;
        end
      end
    end else begin : g_out
      // carry into the MSB recovered from the MSB's own sum bit
      logic w_cm;
      assign w_cm = w_a_src[CHUNK-1] ^ w_b_src[CHUNK-1] ^ w_s[CHUNK-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_sum  <= '0;
          r_cout <= 1'b0;
          r_ovf  <= 1'b0;
          r_zero <= 1'b0;
        end else if (w_adv) begin
          r_sum  <= w_sum_nx;
          r_cout <= w_co;
          r_ovf  <= w_cm ^ w_co;
          r_zero <= (w_sum_nx == '0);
        end
      end
    end
  end

  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld_pipe[STAGES-1];
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: main config (32,4) plus (32,1),(16,2),(64,8).
module tb_pipe_adder;
  localparam int W0 = 32;
  localparam int S0 = 4;

  typedef struct packed {
    logic [127:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  bit sec_go = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [127:0] s, logic c, logic o, logic z);
    exp_t e;
    e.sum = s; e.cout = c; e.ovf = o; e.zero = z;
    return e;
  endfunction

  function automatic exp_t ref_add(int w, logic [127:0] a, logic [127:0] b, logic sub, logic cin);
    exp_t         r;
    logic [127:0] m, am, bp;
    logic [128:0] full;
    m    = (128'd1 << w) - 128'd1;
    am   = a & m;
    bp   = (sub ? ~b : b) & m;
    full = {1'b0, am} + {1'b0, bp} + (sub ? 129'd1 : 129'(cin));
    r.sum  = full[127:0] & m;
    r.cout = full[w];
    r.ovf  = (am[w-1] == bp[w-1]) && (r.sum[w-1] != am[w-1]);
    r.zero = (r.sum == '0);
    return r;
  endfunction

  // ---------------- main DUT ----------------
  pipe_adder_if #(.WIDTH(W0)) m_if ();
  pipe_adder #(.WIDTH(W0), .STAGES(S0)) u_dut (.clk(clk), .rst(rst), .bus(m_if));

  exp_t mq[$];
  int   m_pop_cyc[$];
  int   last_acc;

  always @(negedge clk) begin
    if (!rst && m_if.out_valid && m_if.out_ready) begin
      if (mq.size() == 0) chk("m_spurious_out", 1, 0);
      else begin
        exp_t e;
        e = mq.pop_front();
        chk("m_sum",  128'(m_if.sum), e.sum);
        chk("m_cout", 128'(m_if.cout), 128'(e.cout));
        chk("m_ovf",  128'(m_if.ovf),  128'(e.ovf));
        chk("m_zero", 128'(m_if.zero), 128'(e.zero));
        m_pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic m_push(logic [31:0] a, logic [31:0] b, logic sub, logic cin, exp_t e);
    bit acc = 1'b0;
    m_if.a = a; m_if.b = b; m_if.sub = sub; m_if.cin = cin; m_if.in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = m_if.in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) begin
      mq.push_back(e);
      last_acc = cyc;
    end else chk("m_accept_timeout", 0, 1);
  endtask

  task automatic m_push_rnd(logic sub);
    logic [31:0] ra, rb;
    logic        rc;
    ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
    m_push(ra, rb, sub, rc, ref_add(W0, 128'(ra), 128'(rb), sub, rc));
  endtask

  task automatic m_drain();
    for (int t = 0; t < 200 && mq.size() != 0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("m_drain_left", 128'(mq.size()), 0);
  endtask

  // ---------------- other parameter sets ----------------
  for (genvar g = 0; g < 3; g++) begin : g_cfg
    localparam int W = (g == 0) ? 32 : (g == 1) ? 16 : 64;
    localparam int S = (g == 0) ? 1  : (g == 1) ? 2  : 8;

    pipe_adder_if #(.WIDTH(W)) s_if ();
    pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (.clk(clk), .rst(rst), .bus(s_if));

    exp_t q[$];
    bit   done = 1'b0;

    always @(negedge clk) begin
      if (!rst && s_if.out_valid && s_if.out_ready) begin
        if (q.size() == 0) chk($sformatf("c%0d_spurious_out", g), 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("c%0d_sum", g),  128'(s_if.sum), e.sum);
          chk($sformatf("c%0d_cout", g), 128'(s_if.cout), 128'(e.cout));
          chk($sformatf("c%0d_ovf", g),  128'(s_if.ovf),  128'(e.ovf));
          chk($sformatf("c%0d_zero", g), 128'(s_if.zero), 128'(e.zero));
        end
      end
    end

    initial begin
      logic [W-1:0] ra, rb;
      logic         rs, rc;
      bit           acc;
      s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0;
      s_if.sub = 1'b0; s_if.cin = 1'b0; s_if.out_ready = 1'b1;
      wait (sec_go);
      @(posedge clk);
      #1;
      for (int i = 0; i < 40; i++) begin
        if (i % 2 == 0) begin
          ra = ($urandom_range(0, 3) == 0) ? '1 : W'({$urandom, $urandom});
          rb = ($urandom_range(0, 3) == 0) ? '0 : W'({$urandom, $urandom});
          rs = 1'($urandom_range(0, 1));
          rc = 1'($urandom_range(0, 1));
          s_if.a = ra; s_if.b = rb; s_if.sub = rs; s_if.cin = rc; s_if.in_valid = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = s_if.in_ready;
            @(posedge clk);
            #1;
            if (!acc) s_if.out_ready = 1'b1;
          end
          if (acc) q.push_back(ref_add(W, 128'(ra), 128'(rb), rs, rc));
          else chk($sformatf("c%0d_accept_timeout", g), 0, 1);
        end else begin
          s_if.in_valid = 1'b0;
          s_if.a = W'({$urandom, $urandom});
          @(posedge clk);
          #1;
        end
        s_if.out_ready = ($urandom_range(0, 3) != 0);
      end
      s_if.in_valid  = 1'b0;
      s_if.out_ready = 1'b1;
      for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
      chk($sformatf("c%0d_drain_left", g), 128'(q.size()), 0);
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int first_acc;
    bit all_done;
    m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0;
    m_if.sub = 1'b0; m_if.cin = 1'b0; m_if.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 128'(m_if.out_valid), 0);
    chk("rst_sum",       128'(m_if.sum), 0);
    chk("rst_cout",      128'(m_if.cout), 0);
    chk("rst_ovf",       128'(m_if.ovf), 0);
    chk("rst_zero",      128'(m_if.zero), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 128'(m_if.in_ready), 1);
    @(posedge clk);
    #1;

    // back-to-back stream, latency and throughput
    m_pop_cyc.delete();
    first_acc = 0;
    for (int i = 1; i <= 8; i++) begin
      m_push(32'(i), 32'(2 * i), 1'b0, 1'b0, mk(128'(3 * i), 1'b0, 1'b0, 1'b0));
      if (i == 1) first_acc = last_acc;
    end
    m_if.in_valid = 1'b0;
    m_drain();
    chk("stream_count", 128'(m_pop_cyc.size()), 8);
    if (m_pop_cyc.size() == 8) begin
      chk("latency", 128'(m_pop_cyc[0] - first_acc), 128'(S0 - 1));
      for (int i = 1; i < 8; i++) chk("back_to_back", 128'(m_pop_cyc[i] - m_pop_cyc[i-1]), 1);
    end

    // carries across slices, subtract and overflow
    m_push(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, mk(128'h0001_0000, 1'b0, 1'b0, 1'b0));
    m_push(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, mk(128'h0,         1'b1, 1'b0, 1'b1));
    m_push(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, mk(128'h7FFF_FFFF, 1'b1, 1'b1, 1'b0));
    m_push(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, mk(128'hFFFF_FFFE, 1'b0, 1'b0, 1'b0));
    m_if.in_valid = 1'b0;
    m_drain();

    // back-pressure: fill, hold 5 cycles with a beat offered, release
    m_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) m_push_rnd(1'(i));
    m_if.a = $urandom;
    m_if.b = $urandom;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_in_ready",  128'(m_if.in_ready), 0);
      chk("bp_out_valid", 128'(m_if.out_valid), 1);
      if (mq.size() != 0) chk("bp_sum_hold", 128'(m_if.sum), mq[0].sum);
      @(posedge clk);
      #1;
    end
    m_if.in_valid  = 1'b0;
    m_if.out_ready = 1'b1;
    m_drain();

    // bubbles: out_valid must alternate
    m_pop_cyc.delete();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) m_push_rnd(1'($urandom_range(0, 1)));
      else begin
        m_if.in_valid = 1'b0;
        m_if.a = $urandom;
        @(posedge clk);
        #1;
      end
    end
    m_if.in_valid = 1'b0;
    m_drain();
    chk("bubble_count", 128'(m_pop_cyc.size()), 8);
    if (m_pop_cyc.size() == 8)
      for (int i = 1; i < 8; i++) chk("bubble_spacing", 128'(m_pop_cyc[i] - m_pop_cyc[i-1]), 2);

    // reset with beats in flight and one at the output
    for (int i = 0; i < 4; i++) m_push_rnd(1'b0);
    m_if.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(m_if.out_valid), 0);
    chk("midrst_sum",       128'(m_if.sum), 0);
    chk("midrst_cout",      128'(m_if.cout), 0);
    chk("midrst_ovf",       128'(m_if.ovf), 0);
    mq.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    m_push(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, mk(128'h2345_6789, 1'b0, 1'b0, 1'b0));
    m_if.in_valid = 1'b0;
    m_drain();

    // other parameter sets run together
    sec_go = 1'b1;
    all_done = 1'b0;
    for (int t = 0; t < 5000 && !all_done; t++) begin
      @(posedge clk);
      all_done = g_cfg[0].done && g_cfg[1].done && g_cfg[2].done;
    end
    chk("cfg_runs_done", 128'(all_done), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
